apb_wait_slave: RTL and testbench
=================================

// Module: apb_wait_slave
// PURPOSE
//  - APB completer (slave) with a byte register bank and a programmable wait-state insertion FSM.
//  - Sits downstream of apb_master, on the PSEL/PENABLE/PWRITE/PADDR[7:0]/PWDATA bus.
//  - Drop-in replacement for either slave slot; the parent routes PRDATA/PREADY by PADDR[8].
//  - Exercises the master's PREADY-stall path, which zero-wait slaves never hit.
// PARAMETERS
//  DEPTH        64   number of 8-bit registers; in-range when PADDR < DEPTH; legal 1..256
//  WAIT_CYCLES  2    access-phase cycles with PREADY=0 before completion; legal 0..15
// PORTS
//  PCLK     in   1  clock; all logic on rising edge
//  PRST     in   1  reset, synchronous, active-high
//  PSEL     in   1  slave select from master
//  PENABLE  in   1  access-phase strobe
//  PWRITE   in   1  1=write, 0=read
//  PADDR    in   8  byte address within slave
//  PWDATA   in   8  write data
//  PRDATA   out  8  read data, valid only while PREADY=1
//  PREADY   out  1  transfer completes on the edge where PSEL&PENABLE&PREADY
//  PSLVERR  out  1  error response; port exists only under APB_SLVERR_EN
// BEHAVIOUR
//  - Reset: on an edge with PRST=1, FSM->IDLE, wait counter=0, all DEPTH registers=8'h00,
//    PREADY=0, PRDATA=8'h00, PSLVERR=0. Reset mid-transfer aborts it; no write commits.
//  - FSM states: IDLE, ACCESS.
//  - IDLE -> ACCESS on PSEL=1 & PENABLE=0 (setup). Same edge latches PADDR, PWRITE, PWDATA and
//    loads cnt=WAIT_CYCLES. PSEL=1 & PENABLE=1 while in IDLE (no setup seen) is ignored.
//  - ACCESS: while cnt!=0, cnt decrements each edge and PREADY=0. PREADY = (state==ACCESS && cnt==0)
//    is decoded from registers only, never combinationally from inputs.
//  - Latency: PREADY rises in access cycle WAIT_CYCLES+1; WAIT_CYCLES=0 gives a zero-wait transfer.
//  - Completion edge (PSEL&PENABLE&PREADY): a write to an in-range address commits the latched
//    PWDATA. FSM -> IDLE. A new setup can be accepted on the very next edge, so back-to-back
//    transfers take 2+WAIT_CYCLES cycles each.
//  - Read: PRDATA = reg[latched addr] while PREADY=1, 8'h00 otherwise. Never X.
//  - Abort: PSEL=0 while in ACCESS -> IDLE on that edge. No write, PREADY=0 next cycle.
//  - PADDR/PWDATA changing during ACCESS is ignored; only the setup-edge latch is used.
//  - Out-of-range address (PADDR>=DEPTH): write dropped, read returns 8'h00, timing unchanged.
// CONFIGURATION
//  - APB_SLVERR_EN defined: PSLVERR port present. PSLVERR = PREADY & latched_out_of_range.
//    Out-of-range write dropped, read data 8'h00.
//  - APB_SLVERR_EN undefined: no PSLVERR port. Out-of-range accesses complete silently as above.
// STRUCTURE
//  - apb_pkg holds:
//    - state enum {IDLE, ACCESS}
//    - APB_DATA_W=8, APB_ADDR_W=8
//    - wait counter width WAIT_CNT_W=4
//  - One sub-module: apb_reg_bank. DEPTH x 8 array; synchronous reset-clear;
//    write-enable/addr/data in, async read port out.
//  - The FSM, counter and decode live in apb_wait_slave.
// TESTING
//  1. Reset, then read addr 0x05 (WAIT_CYCLES=2) -> PREADY low for 2 access cycles,
//     high on the 3rd; PRDATA=8'h00.
//  2. Write 0xA5 to 0x10, then read 0x10 back-to-back -> PRDATA=8'hA5.
//     Each transfer 4 cycles setup-to-completion.
//  3. WAIT_CYCLES=0: write 0x3C to 0x3F, read 0x3F -> PREADY high in the 1st access cycle;
//     PRDATA=8'h3C.
//  4. Write 0x77 to 0x40 (DEPTH=64) -> timing normal, no register changes.
//     Read 0x40 -> 8'h00. With APB_SLVERR_EN, PSLVERR=1 on both completions.
//  5. Start write 0x99 to 0x02, then either drop PSEL after 1 access cycle, or assert PRST
//     mid-ACCESS -> IDLE next cycle, PREADY=0, later read 0x02 returns 8'h00.
//  6. Change PADDR/PWDATA during wait cycles of a write 0x11 to 0x08 -> reg 0x08=8'h11;
//     no other register modified.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB completer types and widths.
// Used by apb_wait_slave and apb_reg_bank.
package apb_pkg;

  localparam int APB_DATA_W = 8;
  localparam int APB_ADDR_W = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_reg_bank.sv
// DEPTH x 8 register array, sync clear, async read.
// Addresses at or beyond DEPTH match no entry.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [APB_ADDR_W-1:0] waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [APB_ADDR_W-1:0] raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == APB_ADDR_W'(i)) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == APB_ADDR_W'(i)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/apb_wait_slave.sv
// APB completer with byte register bank and WAIT_CYCLES wait states.
// Define APB_SLVERR_EN to add PSLVERR for out-of-range accesses.
module apb_wait_slave
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRST,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY
`ifdef APB_SLVERR_EN
  ,
  output logic                  PSLVERR
`endif
);

  apb_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [APB_ADDR_W-1:0] addr_q, addr_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  in_rng_q, in_rng_d;
  logic                  setup;
  logic                  done;
  logic                  we;
  logic [APB_DATA_W-1:0] bank_rdata;

  assign setup  = PSEL & ~PENABLE;
  assign PREADY = (state_q == ACCESS) && (cnt_q == '0);
  assign done   = PSEL & PENABLE & PREADY;
  assign we     = done & write_q & in_rng_q;
  assign PRDATA = (PREADY && in_rng_q) ? bank_rdata : '0;

`ifdef APB_SLVERR_EN
  assign PSLVERR = PREADY & ~in_rng_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    in_rng_d = in_rng_q;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d  = ACCESS;
          cnt_d    = WAIT_CNT_W'(WAIT_CYCLES);
          addr_d   = PADDR;
          wdata_d  = PWDATA;
          write_d  = PWRITE;
          in_rng_d = {1'b0, PADDR} < (APB_ADDR_W+1)'(DEPTH);
        end
      end
      ACCESS: begin
        // PSEL drop aborts; no write commits
        if (!PSEL || done) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      in_rng_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      in_rng_q <= in_rng_d;
    end
  end

  apb_reg_bank #(
    .DEPTH(DEPTH)
  ) u_bank (
    .clk  (PCLK),
    .rst  (PRST),
    .we   (we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(addr_q),
    .rdata(bank_rdata)
  );

endmodule

// File: tb/tb_apb_wait_slave.sv
// Scoreboard bench for apb_wait_slave: dut0 has 2 wait states, dut1 has 0.
// Driver pushes expected completions; a negedge monitor pops and checks.
module tb_apb_wait_slave;

  typedef struct {
    logic       wr;
    logic [7:0] rdata;
    int         lat;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [7:0] paddr   [2];
  logic [7:0] pwdata  [2];
  logic [7:0] prdata  [2];
  logic       pready  [2];
`ifdef APB_SLVERR_EN
  logic       pslverr [2];
`endif

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acnt [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  apb_wait_slave #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
    .PCLK   (clk),
    .PRST   (rst),
    .PSEL   (psel[0]),
    .PENABLE(penable[0]),
    .PWRITE (pwrite[0]),
    .PADDR  (paddr[0]),
    .PWDATA (pwdata[0]),
    .PRDATA (prdata[0]),
    .PREADY (pready[0])
`ifdef APB_SLVERR_EN
    ,
    .PSLVERR(pslverr[0])
`endif
  );

  apb_wait_slave #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut1 (
    .PCLK   (clk),
    .PRST   (rst),
    .PSEL   (psel[1]),
    .PENABLE(penable[1]),
    .PWRITE (pwrite[1]),
    .PADDR  (paddr[1]),
    .PWDATA (pwdata[1]),
    .PRDATA (prdata[1]),
    .PREADY (pready[1])
`ifdef APB_SLVERR_EN
    ,
    .PSLVERR(pslverr[1])
`endif
  );

  // Monitor: count access cycles, check each completion
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        acnt[d] = 0;
      end else if (psel[d] && !penable[d]) begin
        acnt[d] = 0;
      end else if (psel[d] && penable[d]) begin
        acnt[d]++;
        if (!pready[d]) begin
          checks++;
          if (prdata[d] !== 8'h00) begin
            failures++;
            $display("FAIL prdata_idle dut%0d got=%h want=00", d, prdata[d]);
          end
        end else if ((d == 0 && q0.size() == 0) ||
                     (d == 1 && q1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done dut%0d", d);
        end else begin
          if (d == 0) me = q0.pop_front();
          else        me = q1.pop_front();
          checks++;
          if (acnt[d] != me.lat) begin
            failures++;
            $display("FAIL latency dut%0d got=%0d want=%0d", d, acnt[d], me.lat);
          end
          if (!me.wr) begin
            checks++;
            if (prdata[d] !== me.rdata) begin
              failures++;
              $display("FAIL rdata dut%0d got=%h want=%h", d, prdata[d], me.rdata);
            end
          end
`ifdef APB_SLVERR_EN
          checks++;
          if (pslverr[d] !== me.err) begin
            failures++;
            $display("FAIL pslverr dut%0d got=%b want=%b", d, pslverr[d], me.err);
          end
`endif
        end
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the completion edge
  task automatic xfer(input int d, input logic wr, input logic [7:0] a,
                      input logic [7:0] wd, input logic [7:0] rd,
                      input logic err, input logic corrupt);
    exp_t e;
    int   t0;
    bit   done;
    e.wr    = wr;
    e.rdata = rd;
    e.lat   = (d == 0) ? 3 : 1;
    e.err   = err;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    t0 = cyc;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = a;
    pwdata[d]  = wd;
    @(posedge clk);
    #1 penable[d] = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (pready[d]) begin
        done = 1'b1;
        break;
      end
      if (corrupt) begin
        paddr[d]  = a ^ 8'h01;
        pwdata[d] = 8'hEE;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout dut%0d addr=%h got=no_pready want=pready", d, a);
    end
    @(posedge clk);
    #1;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    checks++;
    if (cyc - t0 != e.lat + 1) begin
      failures++;
      $display("FAIL xfer_cycles dut%0d got=%0d want=%0d", d, cyc - t0, e.lat + 1);
    end
  endtask

  // Write 0x99 to 0x02 on dut0, then abort by PSEL drop or reset
  task automatic abort_xfer(input bit use_rst);
    psel[0]    = 1'b1;
    penable[0] = 1'b0;
    pwrite[0]  = 1'b1;
    paddr[0]   = 8'h02;
    pwdata[0]  = 8'h99;
    @(posedge clk);
    #1 penable[0] = 1'b1;
    @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1;
    else begin
      psel[0]    = 1'b0;
      penable[0] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst        = 1'b0;
    psel[0]    = 1'b0;
    penable[0] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (pready[0] !== 1'b0) begin
        failures++;
        $display("FAIL abort_pready rst=%0b got=%b want=0", use_rst, pready[0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
      pwrite[d]  = 1'b0;
      paddr[d]   = 8'h00;
      pwdata[d]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pready[d] !== 1'b0 || prdata[d] !== 8'h00) begin
        failures++;
        $display("FAIL reset_out dut%0d got=%b/%h want=0/00", d, pready[d], prdata[d]);
      end
`ifdef APB_SLVERR_EN
      checks++;
      if (pslverr[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_slverr dut%0d got=%b want=0", d, pslverr[d]);
      end
`endif
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Access phase without a setup must be ignored
    psel[0]    = 1'b1;
    penable[0] = 1'b1;
    paddr[0]   = 8'h05;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (pready[0] !== 1'b0) begin
        failures++;
        $display("FAIL no_setup got=%b want=0", pready[0]);
      end
    end
    @(posedge clk);
    #1;
    psel[0]    = 1'b0;
    penable[0] = 1'b0;

    xfer(0, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);
    xfer(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0);

    xfer(1, 1'b1, 8'h3F, 8'h3C, 8'h00, 1'b0, 1'b0);
    xfer(1, 1'b0, 8'h3F, 8'h00, 8'h3C, 1'b0, 1'b0);

    xfer(0, 1'b1, 8'h40, 8'h77, 8'h00, 1'b1, 1'b0);
    xfer(0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0);
    xfer(0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0);

    abort_xfer(1'b0);
    xfer(0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 1'b0);
    abort_xfer(1'b1);
    xfer(0, 1'b0, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0);

    xfer(0, 1'b1, 8'h08, 8'h11, 8'h00, 1'b0, 1'b1);
    xfer(0, 1'b0, 8'h08, 8'h00, 8'h11, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h09, 8'h00, 8'h00, 1'b0, 1'b0);
    xfer(0, 1'b0, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
